// File: rtl/div_seq.sv
// Multi-cycle divide sequencer for the EXE stage: 32-iteration restoring divider for DIV/DIVU,
// with stall generation and registered quotient/remainder held until MEM takes the instruction.
module div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_req,
  input  logic        div_signed,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        div_accept,
  input  logic        div_cancel,
  output logic        div_stall,
  output logic        div_done,
  output logic [31:0] div_quot,
  output logic [31:0] div_rem
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q;
  logic [31:0] a_q;      // dividend magnitude, shifted out MSB-first
  logic [31:0] b_q;      // divisor magnitude
  logic [31:0] q_q;      // quotient bits collected so far
  logic [32:0] r_q;      // partial remainder
  logic [4:0]  cnt_q;
  logic        qsign_q;
  logic        rsign_q;

  logic        src1_neg;
  logic        src2_neg;
  logic [31:0] src1_abs;
  logic [31:0] src2_abs;
  logic [32:0] trial;
  logic        trial_ge;
  logic [32:0] r_nxt;
  logic [31:0] q_nxt;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // The remainder never exceeds the divisor, so its top bit is never consumed.
  logic unused_rem_msb;
  assign unused_rem_msb = r_q[32];

  always_comb begin
    src1_neg = div_signed & div_src1[31];
    src2_neg = div_signed & div_src2[31];
    src1_abs = src1_neg ? (~div_src1 + 32'd1) : div_src1;
    src2_abs = src2_neg ? (~div_src2 + 32'd1) : div_src2;

    trial    = {r_q[31:0], a_q[31]};
    trial_ge = (trial >= {1'b0, b_q});
    r_nxt    = trial_ge ? (trial - {1'b0, b_q}) : trial;
    q_nxt    = {q_q[30:0], trial_ge};

    quot_fix = qsign_q ? (~q_nxt + 32'd1) : q_nxt;
    rem_fix  = rsign_q ? (~r_nxt[31:0] + 32'd1) : r_nxt[31:0];
  end

  assign div_stall = div_req & (state_q != StDone) & ~div_cancel;
  assign div_done  = (state_q == StDone);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      div_quot <= '0;
      div_rem  <= '0;
    end else if (div_cancel) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (div_req) begin
            a_q     <= src1_abs;
            b_q     <= src2_abs;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            qsign_q <= src1_neg ^ src2_neg;
            rsign_q <= src1_neg;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          a_q   <= {a_q[30:0], 1'b0};
          r_q   <= r_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            // Sign fix-up uses the final iteration's values directly.
            div_quot <= quot_fix;
            div_rem  <= rem_fix;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (div_accept) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
